pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer; consumes the next-PC select mux output.

---
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/pc_fetch_unit.sv | 108 ++++++++++
 tb/tb_pc_fetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bundle: next-PC mux link, instruction-memory request/response and decode handoff.
interface pc_fetch_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [31:0] pc_plus4;
    logic [31:0] pc;

    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, pc_plus4, pc
    );

    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, pc_plus4, pc
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Redirects retarget the fetch PC and squash any fetch already accepted by memory.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst,
    pc_fetch_if.master bus
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] if_instr_r;
    logic [31:0] if_pc_r;
    logic        if_valid_r;
    logic        kill_r;
    logic [31:0] target_s;

    // Targets are word aligned; the low two bits of the mux output carry no meaning.
    assign target_s = bus.redirect_pc & 32'hFFFF_FFFC;

    // Fetch sequencer: PC, squash flag and the decode-facing instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_REQ;
            pc_r       <= RESET_PC & 32'hFFFF_FFFC;
            kill_r     <= 1'b0;
            if_valid_r <= 1'b0;
            if_instr_r <= 32'h0000_0000;
            if_pc_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (bus.redirect) begin
                        pc_r <= target_s;
                        // An accepted request for the old address is still in flight.
                        if (bus.imem_req_ready) begin
                            kill_r  <= 1'b1;
                            state_r <= ST_WAIT;
                        end else begin
                            state_r <= ST_REQ;
                        end
                    end else if (bus.imem_req_ready) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rsp_valid && (kill_r || bus.redirect)) begin
                        kill_r  <= 1'b0;
                        state_r <= ST_REQ;
                        if (bus.redirect) begin
                            pc_r <= target_s;
                        end else begin
                            pc_r <= pc_r;
                        end
                    end else if (bus.redirect) begin
                        pc_r   <= target_s;
                        kill_r <= 1'b1;
                    end else if (bus.imem_rsp_valid) begin
                        if_instr_r <= bus.imem_rsp_data;
                        if_pc_r    <= pc_r;
                        if_valid_r <= 1'b1;
                        state_r    <= ST_HOLD;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    // A redirect discards the held instruction even if decode takes it.
                    if (bus.redirect) begin
                        if_valid_r <= 1'b0;
                        pc_r       <= target_s;
                        state_r    <= ST_REQ;
                    end else if (bus.if_ready) begin
                        if_valid_r <= 1'b0;
                        pc_r       <= pc_r + 32'd4;
                        state_r    <= ST_REQ;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r    <= ST_REQ;
                    kill_r     <= 1'b0;
                    if_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Request strobe is decoded from state and held low for as long as reset is asserted.
    assign bus.imem_req_valid = (state_r == ST_REQ) && !rst;
    assign bus.imem_req_addr  = pc_r;
    assign bus.pc             = pc_r;
    assign bus.if_valid       = if_valid_r;
    assign bus.if_instr       = if_instr_r;
    assign bus.if_pc          = if_pc_r;
    assign bus.pc_plus4       = if_pc_r + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a latency-configurable memory model and a scoreboard
// of expected {instr, pc} pairs checked at every decode handshake.
module tb_pc_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_fetch_if bus0();
    pc_fetch_if bus1();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          lat;
    int          cnt;
    logic        pend;
    logic [31:0] paddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_t e;
        e.instr = mem_word(a);
        e.pc    = a;
        sb_q.push_back(e);
    endtask

    task automatic mem_clear();
        pend                = 1'b0;
        cnt                 = 0;
        bus0.imem_rsp_valid = 1'b0;
        bus0.imem_rsp_data  = 32'h0000_0000;
    endtask

    // One clock: sample handshakes mid-cycle, advance, then update the memory model.
    task automatic tick();
        logic        acc_s;
        logic        hs_s;
        logic [31:0] addr_s;
        exp_t        e;
        #1;
        acc_s  = bus0.imem_req_valid && bus0.imem_req_ready;
        addr_s = bus0.imem_req_addr;
        hs_s   = bus0.if_valid && bus0.if_ready && !bus0.redirect;
        if (hs_s) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL hs_unexpected observed pc=%h expected=none", bus0.if_pc);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("hs_instr", bus0.if_instr, e.instr);
                chk("hs_pc", bus0.if_pc, e.pc);
            end
        end
        @(posedge clk);
        #1;
        if (bus0.imem_rsp_valid) pend = 1'b0;
        if (acc_s) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = addr_s;
        end
        if (pend && cnt > 0) cnt--;
        bus0.imem_rsp_valid = pend && (cnt == 0);
        bus0.imem_rsp_data  = pend ? mem_word(paddr) : 32'h0000_0000;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_empty", sb_q.size(), 32'd0);
    endtask

    task automatic wait_if_valid(input int budget);
        int n = 0;
        while (!bus0.if_valid && n < budget) begin
            tick();
            n++;
        end
        chk("if_valid_wait", {31'd0, bus0.if_valid}, 32'd1);
    endtask

    initial begin
        rst                 = 1'b1;
        lat                 = 1;
        paddr               = 32'h0000_0000;
        bus0.redirect       = 1'b0;
        bus0.redirect_pc    = 32'h0000_0000;
        bus0.imem_req_ready = 1'b1;
        bus0.if_ready       = 1'b1;
        mem_clear();
        bus1.redirect       = 1'b0;
        bus1.redirect_pc    = 32'h0000_0000;
        bus1.imem_req_ready = 1'b1;
        bus1.imem_rsp_valid = 1'b1;
        bus1.imem_rsp_data  = 32'hCAFE_F00D;
        bus1.if_ready       = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_req_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
        chk("rst_pc", bus0.pc, 32'h0000_0000);
        chk("rst_if_valid", {31'd0, bus0.if_valid}, 32'd0);
        chk("rst_if_instr", bus0.if_instr, 32'h0000_0000);
        chk("rst_if_pc", bus0.if_pc, 32'h0000_0000);
        chk("rst_pc_hi", bus1.pc, 32'hFFFF_FFFC);

        // Test 1 (dut0) and test 5 (dut1) run side by side from reset release
        rst = 1'b0;
        #1;
        chk("t1_req_valid", {31'd0, bus0.imem_req_valid}, 32'd1);
        chk("t1_req_addr", bus0.imem_req_addr, 32'h0000_0000);
        chk("t5_req_addr", bus1.imem_req_addr, 32'hFFFF_FFFC);
        chk("t5_plus4_rst", bus1.pc_plus4, 32'h0000_0004);
        expect_fetch(32'h0000_0000);
        expect_fetch(32'h0000_0004);
        expect_fetch(32'h0000_0008);
        tick();
        chk("t1_wait_req_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
        tick();
        chk("t1_if_valid", {31'd0, bus0.if_valid}, 32'd1);
        chk("t5_if_pc", bus1.if_pc, 32'hFFFF_FFFC);
        chk("t5_if_instr", bus1.if_instr, 32'hCAFE_F00D);
        chk("t5_plus4_wrap", bus1.pc_plus4, 32'h0000_0000);
        tick();
        chk("t5_next_addr", bus1.imem_req_addr, 32'h0000_0000);
        chk("t5_next_valid", {31'd0, bus1.imem_req_valid}, 32'd1);
        chk("t5_plus4_after", bus1.pc_plus4, 32'h0000_0000);
        drain(40);

        // Test 2: memory stalls the request
        rst = 1'b1;
        mem_clear();
        bus0.imem_req_ready = 1'b0;
        tick();
        chk("t2_rst_req_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
        chk("t2_rst_pc", bus0.pc, 32'h0000_0000);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_valid", {31'd0, bus0.imem_req_valid}, 32'd1);
            chk("t2_stall_addr", bus0.imem_req_addr, 32'h0000_0000);
            chk("t2_stall_if_valid", {31'd0, bus0.if_valid}, 32'd0);
            tick();
        end

        // Test 3: redirect while waiting, stale response arrives afterwards
        bus0.imem_req_ready = 1'b1;
        lat = 2;
        tick();
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h0000_0100;
        tick();
        bus0.redirect = 1'b0;
        chk("t3_pc_redirected", bus0.pc, 32'h0000_0100);
        chk("t3_wait_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
        tick();
        chk("t3_req_valid", {31'd0, bus0.imem_req_valid}, 32'd1);
        chk("t3_req_addr", bus0.imem_req_addr, 32'h0000_0100);
        chk("t3_dropped", {31'd0, bus0.if_valid}, 32'd0);
        lat = 1;
        expect_fetch(32'h0000_0100);
        drain(20);

        // Test 4: decode stalls, then a misaligned redirect discards the held instruction
        bus0.if_ready = 1'b0;
        wait_if_valid(20);
        for (int i = 0; i < 4; i++) begin
            chk("t4_hold_valid", {31'd0, bus0.if_valid}, 32'd1);
            chk("t4_hold_pc", bus0.if_pc, 32'h0000_0104);
            chk("t4_hold_instr", bus0.if_instr, mem_word(32'h0000_0104));
            tick();
        end
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h0000_0203;
        bus0.if_ready    = 1'b1;
        tick();
        bus0.redirect = 1'b0;
        chk("t4_req_addr", bus0.imem_req_addr, 32'h0000_0200);
        chk("t4_req_valid", {31'd0, bus0.imem_req_valid}, 32'd1);
        chk("t4_discarded", {31'd0, bus0.if_valid}, 32'd0);
        expect_fetch(32'h0000_0200);
        drain(20);

        // Test 6: reset lands while a fetch is outstanding
        lat = 3;
        tick();
        chk("t6_in_wait", {31'd0, bus0.imem_req_valid}, 32'd0);
        rst = 1'b1;
        mem_clear();
        tick();
        chk("t6_pc", bus0.pc, 32'h0000_0000);
        chk("t6_if_valid", {31'd0, bus0.if_valid}, 32'd0);
        chk("t6_req_valid", {31'd0, bus0.imem_req_valid}, 32'd0);
        tick();
        chk("t6_req_valid_hold", {31'd0, bus0.imem_req_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_release_valid", {31'd0, bus0.imem_req_valid}, 32'd1);
        chk("t6_release_addr", bus0.imem_req_addr, 32'h0000_0000);
        lat = 1;
        expect_fetch(32'h0000_0000);
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
